// File: rtl/im_load_arbiter_if.sv
// Port bundle for the instruction-memory arbiter: loader stream, fetch address and IM bus.
// The arbiter sits on the slave side; the environment driving loader/fetch sits on master.
interface im_load_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              boot_go;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_ovf;
  logic [10:0]       ld_count;
  logic [ADDR_W-1:0] if_addr;
  logic              cpu_stall;
  logic [ADDR_W-1:0] im_addr;
  logic              im_we;
  logic [DATA_W-1:0] im_din;

  modport slave (
    input  boot_go, ld_start, ld_base, ld_valid, ld_data, ld_last, if_addr,
    output ld_ready, ld_busy, ld_ovf, ld_count, cpu_stall, im_addr, im_we, im_din
  );

  modport master (
    output boot_go, ld_start, ld_base, ld_valid, ld_data, ld_last, if_addr,
    input  ld_ready, ld_busy, ld_ovf, ld_count, cpu_stall, im_addr, im_we, im_din
  );
endinterface

// File: rtl/im_load_arbiter.sv
// Shares the single instruction-memory port between the fetch path and a streaming boot loader,
// stalling the core until the image is loaded (or boot_go releases it).
module im_load_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter bit SWAP      = 1'b0,
  parameter int MAX_WORDS = 1024
) (
  input logic           clk,
  input logic           rst,
  im_load_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] RUN   = 2'd3;

  localparam logic [10:0] MAX_CNT = 11'(MAX_WORDS);

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_addr;
  logic [10:0]       ld_count;
  logic              ld_ovf;
  logic              accept;
  logic [DATA_W-1:0] swapped;
  logic [ADDR_W-1:0] base_aligned;
  logic [10:0]       count_next;

  // Reset must suppress a write even though the state still reads LOAD during the reset cycle.
  assign accept       = (state == LOAD) && bus.ld_valid && !rst;
  assign base_aligned = bus.ld_base & ~ADDR_W'(3);
  assign count_next   = ld_count + 11'd1;

  always_comb begin
    swapped = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      swapped[8*i +: 8] = bus.ld_data[DATA_W-8-8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_addr  <= '0;
      ld_count <= '0;
      ld_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ld_start) begin
            state    <= LOAD;
            wr_addr  <= base_aligned;
            ld_count <= '0;
            ld_ovf   <= 1'b0;
          end else if (bus.boot_go) begin
            state <= RUN;
          end
        end
        LOAD: begin
          if (accept) begin
            wr_addr  <= wr_addr + ADDR_W'(4);
            ld_count <= count_next;
            if (bus.ld_last) begin
              state <= DRAIN;
            end else if (count_next == MAX_CNT) begin
              state  <= DRAIN;
              ld_ovf <= 1'b1;
            end
          end
        end
        DRAIN: state <= RUN;
        RUN: begin
          if (bus.ld_start) begin
            state    <= LOAD;
            wr_addr  <= base_aligned;
            ld_count <= '0;
            ld_ovf   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In RUN the core is stalled only for the cycle in which a reload is requested.
  assign bus.cpu_stall = (state != RUN) || bus.ld_start;
  assign bus.ld_ready  = (state == LOAD);
  assign bus.ld_busy   = (state == LOAD) || (state == DRAIN);
  assign bus.ld_ovf    = ld_ovf;
  assign bus.ld_count  = ld_count;
  assign bus.im_we     = accept;
  assign bus.im_addr   = (state == LOAD) ? wr_addr : bus.if_addr;
  assign bus.im_din    = (state != LOAD) ? '0 : (SWAP ? swapped : bus.ld_data);

endmodule
